// File: rtl/sum_scheduler_pkg.sv
// Shared types and width helpers for the sum scheduler slice.
// Pure declarations: no logic, no latency.
// No flow control lives here; consumers size their ports from these helpers.
package sum_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Sum of LENGTH elements needs clog2(LENGTH) extra bits to avoid overflow.
  function automatic int sum_width(input int length, input int data_width);
    return $clog2(length) + data_width;
  endfunction

  // Requester index width, never narrower than one bit.
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/sum_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, search starts after last_grant.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is actually taken.
module rr_arbiter
  import sum_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any_grant
);

  // Walk requesters from last_grant+1 (wrapping) and take the first active one.
  always_comb begin
    int k;
    logic [IDW-1:0] kk;
    k         = 0;
    kk        = '0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k  = (int'(last_grant) + i) % NUM_REQ;
      kk = IDW'(k);
      if (!any_grant && req[kk]) begin
        grant[kk] = 1'b1;
        grant_idx = kk;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sum_scheduler.sv
// Shares one sum engine among NUM_REQ requesters, one job in flight, round-robin.
// Latency: accept -> engine enabled next cycle -> response the cycle after eng_sum_done.
// Backpressure: response held stable until rsp_ready; no new accept until then.
// Optional watchdog: define SUM_SCHEDULER_TIMEOUT_EN to bound RUN at TIMEOUT_CYCLES.
module sum_scheduler
  import sum_sched_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DATA_WIDTH     = 32,
  parameter  int LENGTH         = 8,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int SUM_W          = sum_width(LENGTH, DATA_WIDTH),
  localparam int IDW            = id_width(NUM_REQ)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ-1:0][LENGTH-1:0][DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic [LENGTH-1:0][DATA_WIDTH-1:0]             eng_data,
  output logic                                          eng_sum_en,
  input  logic [SUM_W-1:0]                              eng_sum_result,
  input  logic                                          eng_sum_done,
  output logic                                          rsp_valid,
  input  logic                                          rsp_ready,
  output logic [IDW-1:0]                                rsp_id,
  output logic [SUM_W-1:0]                              rsp_sum,
  output logic                                          rsp_err
);

  // Reject configurations outside the supported range at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 16 || LENGTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sum_scheduler: unsupported parameter set");
  end

  state_t               state;
  logic [IDW-1:0]       last_grant;
  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       grant_idx;
  logic                 any_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  // The accept strobe must coincide with the cycle the request is seen.
  assign req_ready = (state == IDLE) ? grant : '0;

`ifdef SUM_SCHEDULER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Scheduler FSM: accept in IDLE, drive engine in RUN, hold response in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      eng_sum_en <= 1'b0;
      eng_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
`ifdef SUM_SCHEDULER_TIMEOUT_EN
      wd_cnt     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_grant) begin
            eng_data   <= req_data[grant_idx];
            rsp_id     <= grant_idx;
            eng_sum_en <= 1'b1;
            state      <= RUN;
`ifdef SUM_SCHEDULER_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
          end
        end
        RUN: begin
          if (eng_sum_done) begin
            rsp_sum    <= eng_sum_result;
            eng_sum_en <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
`ifdef SUM_SCHEDULER_TIMEOUT_EN
            err_q      <= 1'b0;
          end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Engine never answered: release the requester with an error.
            rsp_sum    <= '0;
            err_q      <= 1'b1;
            eng_sum_en <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            wd_cnt     <= wd_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_scheduler.sv
// Self-checking bench for sum_scheduler: vector table, fairness, reset, watchdog.
// Engine model answers ENG_LAT cycles after enable; scoreboard checks every response.
// Response backpressure is exercised by holding rsp_ready low per table entry.
module tb_sum_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int LN = 8;
  localparam int SW = 11;
  localparam int ENG_LAT = 4;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [NR-1:0]                req_valid = '0;
  logic [NR-1:0][LN-1:0][DW-1:0] req_data = '0;
  logic [NR-1:0]                req_ready;
  logic [LN-1:0][DW-1:0]        eng_data;
  logic                         eng_sum_en;
  logic [SW-1:0]                eng_sum_result = '0;
  logic                         eng_sum_done = 1'b0;
  logic                         rsp_valid;
  logic                         rsp_ready = 1'b0;
  logic [1:0]                   rsp_id;
  logic [SW-1:0]                rsp_sum;
  logic                         rsp_err;

  sum_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LENGTH(LN), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .eng_data(eng_data), .eng_sum_en(eng_sum_en), .eng_sum_result(eng_sum_result),
    .eng_sum_done(eng_sum_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] vsum(input logic [LN-1:0][DW-1:0] v);
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < LN; i++) s = s + SW'(v[i]);
    return s;
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int i = 1; i <= NR; i++) begin
      if (v[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  // Scoreboard / engine model
  typedef struct {
    logic [1:0]    id;
    logic [SW-1:0] sum;
    logic          err;
  } exp_t;
  exp_t sb[$];
  int   ptr = NR - 1;
  bit   busy = 0;
  bit   just_acc = 0;
  bit   eng_stall = 0;
  int   ecnt = 0;
  logic [LN-1:0][DW-1:0] exp_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0; just_acc = 0; ptr = NR - 1; sb.delete();
        ecnt = 0; eng_sum_done = 1'b0;
      end else begin
        if (eng_sum_en && !eng_stall) begin
          ecnt++;
          if (ecnt >= ENG_LAT) begin
            eng_sum_done   = 1'b1;
            eng_sum_result = vsum(eng_data);
          end
        end else begin
          ecnt = 0;
          eng_sum_done = 1'b0;
        end
        if (just_acc) begin
          chk("eng_en_after_accept", eng_sum_en, 1);
          chk("eng_data_latched", eng_data, exp_data);
          just_acc = 0;
        end
        if (!busy) begin
          int g;
          exp_t e;
          g = rr_pick(req_valid, ptr);
          chk("req_ready_idle", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
          chk("rsp_valid_idle", rsp_valid, 0);
          if (g >= 0) begin
            busy = 1; just_acc = 1;
            exp_data = req_data[g];
            e.id  = 2'(g);
            e.err = eng_stall;
            e.sum = eng_stall ? '0 : vsum(req_data[g]);
            sb.push_back(e);
          end
        end else begin
          chk("req_ready_busy", req_ready, 0);
          if (rsp_valid) begin
            chk("eng_en_resp", eng_sum_en, 0);
            if (rsp_ready) begin
              chk("sb_depth", sb.size(), 1);
              if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rsp_id", rsp_id, e.id);
                chk("sb_rsp_sum", rsp_sum, e.sum);
                chk("sb_rsp_err", rsp_err, e.err);
                ptr = int'(e.id);
              end
              busy = 0;
            end
          end
        end
      end
    end
  end

  // Table-driven vectors
  typedef struct {
    logic [NR-1:0]         valid;
    logic [NR-1:0][DW-1:0] vals;
    int                    hold;
    int                    exp_id;
    int                    exp_sum;
  } vec_t;
  vec_t tbl[7];

  function automatic vec_t mk(input logic [NR-1:0] v, input logic [7:0] a0, a1, a2, a3,
                              input int hold, input int id, input int sum);
    vec_t t;
    t.valid = v;
    t.vals[0] = a0; t.vals[1] = a1; t.vals[2] = a2; t.vals[3] = a3;
    t.hold = hold; t.exp_id = id; t.exp_sum = sum;
    return t;
  endfunction

  task automatic wait_ready();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin ok = 1; break; end
    end
    chk("accept_wait", ok, 1);
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    chk("rsp_wait", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fair_exp[5];
    tbl[0] = mk(4'b0010, 8'h09, 8'h05, 8'h07, 8'h03, 0,  1, 40);
    tbl[1] = mk(4'b1111, 8'hFF, 8'h11, 8'hFF, 8'h22, 10, 2, 2040);
    tbl[2] = mk(4'b1011, 8'h01, 8'h02, 8'h03, 8'h04, 2,  3, 32);
    tbl[3] = mk(4'b0011, 8'h10, 8'h20, 8'h30, 8'h40, 0,  0, 128);
    tbl[4] = mk(4'b0001, 8'h00, 8'h00, 8'h00, 8'h00, 1,  0, 0);
    tbl[5] = mk(4'b1100, 8'h01, 8'h02, 8'h80, 8'h03, 0,  2, 1024);
    tbl[6] = mk(4'b0101, 8'h07, 8'h01, 8'h01, 8'h01, 3,  0, 56);
    fair_exp = '{0, 1, 2, 3, 0};

    // Reset state, both during and after reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_eng_en", eng_sum_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_eng_data", eng_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_err", rsp_err, 0);

    // Vector table with per-entry response backpressure
    foreach (tbl[n]) begin
      @(posedge clk); #1;
      for (int r = 0; r < NR; r++)
        for (int e = 0; e < LN; e++) req_data[r][e] = tbl[n].vals[r];
      req_valid = tbl[n].valid;
      rsp_ready = 1'b0;
      wait_ready();
      chk("tbl_grant", req_ready, 64'd1 << tbl[n].exp_id);
      @(posedge clk); #1 req_valid = '0;
      wait_rsp();
      chk("tbl_rsp_id", rsp_id, tbl[n].exp_id);
      chk("tbl_rsp_sum", rsp_sum, tbl[n].exp_sum);
      chk("tbl_rsp_err", rsp_err, 0);
      repeat (tbl[n].hold) begin
        @(negedge clk);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_sum", rsp_sum, tbl[n].exp_sum);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
    end

    // Reset in the middle of a job: job discarded, pointer back to requester 0
    @(posedge clk); #1;
    req_valid = 4'b0100;
    wait_ready();
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("midrun_rst_eng_en", eng_sum_en, 0);
    chk("midrun_rst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Fairness with all requesters active and no response backpressure
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_ready();
      chk("fair_grant", req_ready, 64'd1 << fair_exp[j]);
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (12) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b0;

`ifdef SUM_SCHEDULER_TIMEOUT_EN
    // Engine never completes: watchdog releases with an error after 16 RUN cycles
    begin
      int cyc;
      bit seen;
      eng_stall = 1;
      req_valid = 4'b0001;
      wait_ready();
      @(posedge clk); #1 req_valid = '0;
      cyc = 0; seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        cyc++;
        if (rsp_valid) begin seen = 1; break; end
      end
      chk("wd_rsp_seen", seen, 1);
      chk("wd_cycles", cyc, 17);
      chk("wd_rsp_err", rsp_err, 1);
      chk("wd_rsp_sum", rsp_sum, 0);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      eng_stall = 0;
    end
`endif

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_scheduler.md
SUM_SCHEDULER -- requirements
Module: sum_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one sum engine (2..16).
REQ-002 Parameter DATA_WIDTH, default 32, element width.
REQ-003 Parameter LENGTH, default 8, elements per job; need not be a power of 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, watchdog limit in RUN (used only with SUM_SCHEDULER_TIMEOUT_EN).
REQ-005 Derived width SUM_W = $clog2(LENGTH)+DATA_WIDTH; IDW = max(1,$clog2(NUM_REQ)).
REQ-006 clk  input  1  clock; all logic rising-edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 req_valid  input  NUM_REQ  per-requester job request.
REQ-009 req_data  input  NUM_REQ x LENGTH x DATA_WIDTH  per-requester operand vector.
REQ-010 req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-011 eng_data  output  LENGTH x DATA_WIDTH  registered operands to sum engine.
REQ-012 eng_sum_en  output  1  sum engine enable.
REQ-013 eng_sum_result  input  SUM_W  engine result.
REQ-014 eng_sum_done  input  1  engine completion.
REQ-015 rsp_valid / rsp_ready  output / input  1 each  result handshake.
REQ-016 rsp_id  output  IDW  index of requester owning the result.
REQ-017 rsp_sum  output  SUM_W  captured sum.
REQ-018 rsp_err  output  1  watchdog error flag.

Function
REQ-019 FSM states IDLE, RUN, RESP; exactly one job in flight.
REQ-020 IDLE: if any req_valid, round-robin pick starting at (last_grant+1) mod NUM_REQ; assert req_ready[g] for exactly that cycle; latch req_data[g] to eng_data and g to rsp_id; next RUN.
REQ-021 IDLE with no req_valid: all req_ready low, remain IDLE.
REQ-022 RUN: eng_sum_en=1 continuously from the cycle after accept; eng_data held stable.
REQ-023 RUN and eng_sum_done=1: capture eng_sum_result into rsp_sum, rsp_err=0, next RESP.
REQ-024 RESP: eng_sum_en=0, rsp_valid=1; rsp_id/rsp_sum/rsp_err stable until rsp_valid&rsp_ready.
REQ-025 On rsp handshake: last_grant<=rsp_id, next IDLE; eng_sum_en thus low >=1 cycle between jobs (engine clear).
REQ-026 Minimum accept-to-accept period: accept(T), RUN from T+1, RESP >= first cycle after done, IDLE, next accept.
REQ-027 req_valid dropped while not granted: request ignored, no state effect; req_valid of granted requester is don't-care after accept.
REQ-028 eng_sum_done outside RUN: ignored.
REQ-029 Result width SUM_W, zero-extended copy, no truncation.

Reset
REQ-030 rst asserted at any time (including mid-RUN or RESP): state IDLE, req_ready=0, eng_sum_en=0, eng_data=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_err=0, last_grant=NUM_REQ-1 (requester 0 wins first), watchdog counter=0.
REQ-031 Job in flight at reset is discarded; no response issued.

Configuration
REQ-032 Macro SUM_SCHEDULER_TIMEOUT_EN defined: counter clears on RUN entry, increments each RUN cycle; reaching TIMEOUT_CYCLES without eng_sum_done forces RESP with rsp_sum=0, rsp_err=1.
REQ-033 Macro undefined: no counter, rsp_err tied 0, RUN waits indefinitely.

Structure
REQ-034 Package sum_sched_pkg: state enum (IDLE, RUN, RESP), SUM_W/IDW width function.
REQ-035 Sub-module rr_arbiter (NUM_REQ, req vector, last_grant pointer -> one-hot grant + index), purely combinational.

Verification
REQ-036 Single req: req_valid=4'b0010, data all 5, LENGTH=8 -> req_ready=4'b0010 one cycle, eng_sum_en next cycle, rsp_id=1, rsp_sum=40.
REQ-037 Fairness: req_valid=4'b1111 held, rsp_ready=1 -> grants order 0,1,2,3,0.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_sum stable, no new req_ready, eng_sum_en=0.
REQ-039 Max values: DATA_WIDTH=8, all 8'hFF, LENGTH=8 -> rsp_sum=2040 (11 bits), no overflow.
REQ-040 Reset mid-RUN: rst pulse -> eng_sum_en=0 same cycle, no rsp_valid, next grant to requester 0.
REQ-041 With SUM_SCHEDULER_TIMEOUT_EN, TIMEOUT_CYCLES=16, eng_sum_done held 0 -> after 16 RUN cycles rsp_valid=1, rsp_err=1, rsp_sum=0.
